// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// master = producer/consumer side (testbench, upstream/downstream), slave = the unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_ones, out_parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: WIDTH-bit, 8-op bitwise logic unit with a 2-stage
// valid/ready pipeline (S1 operand capture, S2 compute + flags).
// Optional: define LOGIC_UNIT_STATS_EN to add a saturating 16-bit op_count
// port counting output handshakes.
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_unit_pipe_if.slave      bus
`ifdef LOGIC_UNIT_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;

    // Stage 1 operand registers
    logic             r_s1_v;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;

    // Stage 2 result registers
    logic             r_out_v;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ones;
    logic             r_par;

    logic             w_in_ready;
    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_y;

    // S1 frees up whenever S2 can take its beat; combinational from out_ready
    // so a full pipe still streams one beat per cycle.
    assign w_in_ready = ~r_s1_v | ~r_out_v | bus.out_ready;
    assign w_s1_load  = bus.in_valid & w_in_ready;
    assign w_s2_load  = r_s1_v & (~r_out_v | bus.out_ready);

    // Op decode on the S1 registers
    always_comb begin
        w_y = r_a;
        case (r_op)
            OP_AND:  w_y = r_a & r_b;
            OP_OR:   w_y = r_a | r_b;
            OP_XOR:  w_y = r_a ^ r_b;
            OP_NAND: w_y = ~(r_a & r_b);
            OP_NOR:  w_y = ~(r_a | r_b);
            OP_XNOR: w_y = ~(r_a ^ r_b);
            OP_ANDN: w_y = r_a & ~r_b;
            default: w_y = r_a;
        endcase
    end

    // S1: capture an accepted beat; drop the valid when S2 drains it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_v <= 1'b1;
                r_a    <= bus.in_a;
                r_b    <= bus.in_b;
                r_op   <= bus.in_op;
            end else if (w_s2_load) begin
                r_s1_v <= 1'b0;
            end
        end
    end

    // S2: result and flags load together so the flags always describe out_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_y     <= '0;
            r_zero  <= 1'b1;
            r_ones  <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_out_v <= 1'b1;
                r_y     <= w_y;
                r_zero  <= (w_y == '0);
                r_ones  <= (w_y == {WIDTH{1'b1}});
                r_par   <= ^w_y;
            end else if (bus.out_ready) begin
                r_out_v <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_v;
    assign bus.out_y      = r_y;
    assign bus.out_zero   = r_zero;
    assign bus.out_ones   = r_ones;
    assign bus.out_parity = r_par;

`ifdef LOGIC_UNIT_STATS_EN
    logic [15:0] r_op_count;

    // Count output handshakes, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (r_out_v && bus.out_ready && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
